// File: rtl/sample_scheduler_if.sv
// Handshake bundle between sample_scheduler (master) and the sample datapath /
// clk_counter side (slave). N_CH sizes the channel index exactly as in the scheduler.
interface sample_scheduler_if #(
   parameter int N_CH = 2
);
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic            i_start;
   logic            i_stop;
   logic            i_tick;
   logic            o_cnt_enable;
   logic            o_req;
   logic [CH_W-1:0] o_ch;
   logic            i_ack;
   logic            o_frame_done;
   logic            o_busy;
   logic            o_overrun;
   logic            i_clr_overrun;
   logic            o_timeout;

   modport master (
      input  i_start, i_stop, i_tick, i_ack, i_clr_overrun,
      output o_cnt_enable, o_req, o_ch, o_frame_done, o_busy, o_overrun, o_timeout
   );

   modport slave (
      output i_start, i_stop, i_tick, i_ack, i_clr_overrun,
      input  o_cnt_enable, o_req, o_ch, o_frame_done, o_busy, o_overrun, o_timeout
   );
endinterface

// File: rtl/sample_scheduler.sv
// Per-sample sequencer: on each sample-tick rising edge, walks N_CH channels through
// req/ack, then pulses frame-done. Optional ack timeout enabled by SCHED_TIMEOUT_EN.
module sample_scheduler #(
   parameter int N_CH        = 2,
   parameter int ACK_TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                i_rst,
   sample_scheduler_if.master  bus
);
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

   typedef enum logic [1:0] {IDLE, ARMED, REQ, GAP} state_t;

   state_t          state_q, state_n;
   logic            cnt_en_q, cnt_en_n;
   logic            req_q, req_n;
   logic [CH_W-1:0] ch_q, ch_n;
   logic            done_q, done_n;
   logic            overrun_q, overrun_n;
   logic            stop_pend_q, stop_pend_n;
   logic            tick_q;
   logic            tick_rise;
   logic            busy;
   logic            timed_out;
   logic            ack_eff;
   logic            stop_now;

   assign tick_rise = bus.i_tick & ~tick_q;
   assign busy      = (state_q == REQ) || (state_q == GAP);
   assign ack_eff   = bus.i_ack | timed_out;
   // A stop arriving together with the last ack still ends the run after this frame.
   assign stop_now  = stop_pend_q | bus.i_stop;

   // NOTE: every variable gets its default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_n     = state_q;
      cnt_en_n    = cnt_en_q;
      req_n       = req_q;
      ch_n        = ch_q;
      done_n      = 1'b0;
      stop_pend_n = stop_pend_q;
      case (state_q)
         IDLE: begin
            stop_pend_n = 1'b0;
            if (bus.i_start) begin
               state_n  = ARMED;
               cnt_en_n = 1'b1;
            end
         end
         ARMED: begin
            if (bus.i_stop) begin
               state_n  = IDLE;
               cnt_en_n = 1'b0;
            end else if (tick_rise) begin
               state_n = REQ;
               ch_n    = '0;
               req_n   = 1'b1;
            end
         end
         REQ: begin
            if (bus.i_stop) stop_pend_n = 1'b1;
            if (ack_eff) begin
               req_n = 1'b0;
               if (ch_q == LAST_CH) begin
                  done_n = 1'b1;
                  if (stop_now) begin
                     state_n     = IDLE;
                     cnt_en_n    = 1'b0;
                     stop_pend_n = 1'b0;
                  end else begin
                     state_n = ARMED;
                  end
               end else begin
                  ch_n    = ch_q + 1'b1;
                  state_n = GAP;
               end
            end
         end
         GAP: begin
            if (bus.i_stop) stop_pend_n = 1'b1;
            state_n = REQ;
            req_n   = 1'b1;
         end
         default: state_n = IDLE;
      endcase
      // Overrun drops the tick; a coincident clear loses to a new set.
      overrun_n = (overrun_q & ~bus.i_clr_overrun) | (tick_rise & busy);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= IDLE;
         cnt_en_q    <= 1'b0;
         req_q       <= 1'b0;
         ch_q        <= '0;
         done_q      <= 1'b0;
         overrun_q   <= 1'b0;
         stop_pend_q <= 1'b0;
         tick_q      <= 1'b0;
      end else begin
         state_q     <= state_n;
         cnt_en_q    <= cnt_en_n;
         req_q       <= req_n;
         ch_q        <= ch_n;
         done_q      <= done_n;
         overrun_q   <= overrun_n;
         stop_pend_q <= stop_pend_n;
         tick_q      <= bus.i_tick;
      end
   end

`ifdef SCHED_TIMEOUT_EN
   localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
   logic [TO_W-1:0] to_cnt_q;
   logic            timeout_q;

   // Counter restarts on every entry into REQ; the last waiting cycle acts as the ack.
   assign timed_out = (state_q == REQ) && !bus.i_ack && (to_cnt_q == TO_W'(ACK_TIMEOUT - 1));

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         to_cnt_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         to_cnt_q  <= (state_q == REQ && state_n == REQ) ? to_cnt_q + 1'b1 : '0;
         timeout_q <= (timeout_q & ~bus.i_clr_overrun) | timed_out;
      end
   end

   assign bus.o_timeout = timeout_q;
`else
   localparam int unused_ack_timeout = ACK_TIMEOUT;
   assign timed_out     = 1'b0;
   assign bus.o_timeout = 1'b0;
`endif

   assign bus.o_cnt_enable = cnt_en_q;
   assign bus.o_req        = req_q;
   assign bus.o_ch         = ch_q;
   assign bus.o_frame_done = done_q;
   assign bus.o_busy       = busy;
   assign bus.o_overrun    = overrun_q;
endmodule

// File: tb/tb_sample_scheduler.sv
// Self-checking bench for sample_scheduler: directed scenarios plus randomized
// stimulus compared every cycle against a frame-level reference model.
module tb_sample_scheduler;
   localparam int N_CH        = 2;
   localparam int ACK_TIMEOUT = 64;

   logic clk = 1'b0;
   logic i_rst;
   always #5 clk = ~clk;

   sample_scheduler_if #(.N_CH(N_CH)) bus ();
   sample_scheduler #(.N_CH(N_CH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
      .clk(clk), .i_rst(i_rst), .bus(bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: where the scheduler is in the sample frame and what it shows.
   typedef enum {M_IDLE, M_ARMED, M_SERVICE} mode_t;
   mode_t m_mode;
   int    m_ch, m_age;
   bit    m_req, m_cnt_en, m_done, m_ov, m_to, m_pend, m_tick_q;

   task automatic model_reset();
      m_mode = M_IDLE; m_ch = 0; m_age = 0;
      m_req = 0; m_cnt_en = 0; m_done = 0; m_ov = 0; m_to = 0; m_pend = 0; m_tick_q = 0;
   endtask

   task automatic model_step(input bit st, input bit sp, input bit tk, input bit ak, input bit clr);
      bit rise, was_busy, hit, ack;
      rise     = tk && !m_tick_q;
      was_busy = (m_mode == M_SERVICE);
      hit      = 0;
`ifdef SCHED_TIMEOUT_EN
      hit = was_busy && m_req && !ak && (m_age == ACK_TIMEOUT - 1);
`endif
      ack    = ak || hit;
      m_done = 0;
      case (m_mode)
         M_IDLE: if (st) begin m_mode = M_ARMED; m_cnt_en = 1; end
         M_ARMED: begin
            if (sp) begin m_mode = M_IDLE; m_cnt_en = 0; end
            else if (rise) begin m_mode = M_SERVICE; m_ch = 0; m_req = 1; m_age = 0; end
         end
         default: begin
            if (sp) m_pend = 1;
            if (!m_req) begin
               m_req = 1; m_age = 0;
            end else if (!ack) begin
               m_age++;
            end else begin
               m_req = 0;
               if (m_ch == N_CH - 1) begin
                  m_done = 1;
                  if (m_pend) begin m_mode = M_IDLE; m_cnt_en = 0; m_pend = 0; end
                  else m_mode = M_ARMED;
               end else begin
                  m_ch++;
               end
            end
         end
      endcase
      if (clr) begin m_ov = 0; m_to = 0; end
      if (was_busy && rise) m_ov = 1;
      if (hit) m_to = 1;
      m_tick_q = tk;
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".cnt_enable"}, 32'(bus.o_cnt_enable), 32'(m_cnt_en));
      check({tag, ".req"},        32'(bus.o_req),        32'(m_req));
      check({tag, ".ch"},         32'(bus.o_ch),         32'(m_ch));
      check({tag, ".frame_done"}, 32'(bus.o_frame_done), 32'(m_done));
      check({tag, ".busy"},       32'(bus.o_busy),       32'(m_mode == M_SERVICE));
      check({tag, ".overrun"},    32'(bus.o_overrun),    32'(m_ov));
      check({tag, ".timeout"},    32'(bus.o_timeout),    32'(m_to));
   endtask

   // Stimulus state and simple observation counters
   bit d_start, d_stop, d_tick, d_clr, ack_noise;
   int ack_delay;
   int done_cnt, rise_cnt;
   int rise_ch[$];
   bit prev_req;

   task automatic clear_obs();
      done_cnt = 0; rise_cnt = 0; rise_ch.delete();
   endtask

   // Called just after a rising edge; drives the next cycle's inputs and checks its result.
   task automatic step(input string tag);
      bit a;
      a = (m_mode == M_SERVICE) && m_req && (ack_delay >= 0) && (m_age >= ack_delay);
      if (ack_noise && !m_req && $urandom_range(0, 7) == 0) a = 1;
      bus.i_start = d_start; bus.i_stop = d_stop; bus.i_tick = d_tick;
      bus.i_ack = a; bus.i_clr_overrun = d_clr;
      model_step(d_start, d_stop, d_tick, a, d_clr);
      @(posedge clk); #1;
      compare_all(tag);
      if (bus.o_frame_done === 1'b1) done_cnt++;
      if (bus.o_req === 1'b1 && !prev_req) begin rise_cnt++; rise_ch.push_back(int'(bus.o_ch)); end
      prev_req = (bus.o_req === 1'b1);
      d_start = 0; d_stop = 0; d_clr = 0;
   endtask

   task automatic do_reset(input string tag);
      i_rst = 1'b1;
      #1;
      model_reset();
      compare_all(tag);
      @(posedge clk); #1;
      compare_all({tag, "_held"});
      i_rst = 1'b0;
      prev_req = 0;
   endtask

   initial begin
      int hi, lo;
      i_rst = 1'b1;
      bus.i_start = 0; bus.i_stop = 0; bus.i_tick = 0; bus.i_ack = 0; bus.i_clr_overrun = 0;
      d_start = 0; d_stop = 0; d_tick = 0; d_clr = 0; ack_noise = 0; ack_delay = -1;
      prev_req = 0;
      clear_obs();
      @(posedge clk); #1;
      do_reset("reset");

      // Reset while a request is outstanding
      d_start = 1; step("t1");
      d_tick = 1;  step("t1");
      d_tick = 0;  step("t1");
      check("t1_req_before_reset", 32'(bus.o_req), 32'd1);
      do_reset("t1_reset");

      // Full frame, ack three cycles after each request
      clear_obs();
      ack_delay = 3;
      d_start = 1; step("t2");
      d_tick = 1;  step("t2");
      d_tick = 0;
      for (int i = 0; i < 20; i++) step("t2");
      check("t2_done_pulses", 32'(done_cnt), 32'd1);
      check("t2_req_rises", 32'(rise_cnt), 32'd2);
      check("t2_first_ch", 32'(rise_ch.size() > 0 ? rise_ch[0] : 99), 32'd0);
      check("t2_second_ch", 32'(rise_ch.size() > 1 ? rise_ch[1] : 99), 32'd1);
      check("t2_overrun", 32'(bus.o_overrun), 32'd0);
      check("t2_cnt_enable", 32'(bus.o_cnt_enable), 32'd1);

      // Stalled ack across the next tick edge raises overrun; clear drops it
      ack_delay = -1;
      d_tick = 1; step("t3");
      d_tick = 0;
      for (int i = 0; i < 4; i++) step("t3");
      d_tick = 1; step("t3");
      check("t3_overrun_set", 32'(bus.o_overrun), 32'd1);
      d_tick = 0; d_clr = 1; step("t3");
      check("t3_overrun_clr", 32'(bus.o_overrun), 32'd0);
      ack_delay = 0;
      for (int i = 0; i < 10; i++) step("t3");

      // Stop during channel 0: frame completes, enable drops with frame-done
      clear_obs();
      ack_delay = 3;
      d_tick = 1; step("t4");
      d_tick = 0; step("t4");
      d_stop = 1; step("t4");
      for (int i = 0; i < 20; i++) begin
         step("t4");
         if (bus.o_frame_done === 1'b1) check("t4_cnt_en_at_done", 32'(bus.o_cnt_enable), 32'd0);
      end
      check("t4_done_seen", 32'(done_cnt), 32'd1);
      clear_obs();
      for (int k = 0; k < 2; k++) begin
         d_tick = 1; step("t4_idle");
         d_tick = 0;
         for (int i = 0; i < 5; i++) step("t4_idle");
      end
      check("t4_no_req_after_stop", 32'(rise_cnt), 32'd0);

      // Stop and tick edge in the same cycle while armed: stop wins
      clear_obs();
      d_start = 1; step("t5");
      step("t5");
      d_stop = 1; d_tick = 1; step("t5");
      d_tick = 0;
      for (int i = 0; i < 5; i++) step("t5");
      check("t5_no_req", 32'(rise_cnt), 32'd0);
      check("t5_cnt_enable", 32'(bus.o_cnt_enable), 32'd0);

      // Missing ack: wait forever, or time out when the feature is built in
      ack_delay = -1;
      d_start = 1; step("t6");
      d_tick = 1;  step("t6");
      d_tick = 0;
      for (int i = 0; i < 80; i++) step("t6");
`ifdef SCHED_TIMEOUT_EN
      check("t6_timeout", 32'(bus.o_timeout), 32'd1);
      check("t6_ch_advanced", 32'(bus.o_ch), 32'd1);
`else
      check("t6_req_held", 32'(bus.o_req), 32'd1);
      check("t6_timeout", 32'(bus.o_timeout), 32'd0);
`endif
      do_reset("t6_reset");

      // Randomized traffic: irregular tick spacing, variable ack latency, stray acks
      ack_noise = 1;
      lo = 5; hi = 0;
      for (int n = 0; n < 3000; n++) begin
         if (d_tick) begin
            hi--;
            if (hi <= 0) begin d_tick = 0; lo = $urandom_range(4, 36); end
         end else begin
            lo--;
            if (lo <= 0) begin d_tick = 1; hi = $urandom_range(1, 2); end
         end
         d_start = ($urandom_range(0, 29) == 0);
         d_stop  = ($urandom_range(0, 79) == 0);
         d_clr   = ($urandom_range(0, 19) == 0);
         if (m_req && m_age == 0) ack_delay = $urandom_range(0, 4);
         if ($urandom_range(0, 1499) == 0) do_reset("rand_reset");
         else step("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
